output_port_allocator: RTL and testbench
========================================

OUTPUT_PORT_ALLOCATOR -- requirements
Module: output_port_allocator

Interface
REQ-001 The block SHALL have parameter CREDIT_MAX, default 4, which is the downstream input-buffer depth in flits (legal range 1..7).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 4 bits: req[i]=1 means input port i presents a flit destined for this output.
REQ-005 The block SHALL have port tail, input, 4 bits: tail[i]=1 means port i's presented flit is the packet's last flit (single-flit packet: tail=1).
REQ-006 The block SHALL have port credit_in, input, 1 bit: a one-cycle pulse meaning downstream freed one buffer slot.
REQ-007 The block SHALL have port grant_valid, output, 1 bit: the output is locked to an input port.
REQ-008 The block SHALL have port grant_id, output, 2 bits: the index of the locked input port.
REQ-009 The block SHALL have port flit_fire, output, 1 bit: one flit transfers from port grant_id this cycle.
REQ-010 The block SHALL have port credits, output, 3 bits: the current downstream credit count.
REQ-011 The block SHALL have port credit_err, output, 1 bit: a sticky flag set when a credit overflow occurs.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (grant_valid=0) and LOCKED (grant_valid=1).
REQ-013 In IDLE, when |req=1 and credits>0, the block SHALL select a winner round-robin, register grant_id=winner, set grant_valid=1 and enter LOCKED on the next edge; request-to-grant latency is 1 cycle.
REQ-014 Round-robin search order SHALL be last+1, last+2, last+3, last (mod 4), where last is the most recently released grant_id.
REQ-015 In IDLE with credits==0, or with req==0, the block SHALL issue no grant, and last SHALL be unchanged.
REQ-016 flit_fire SHALL be combinational: flit_fire = grant_valid & req[grant_id] & (credits!=0); flit_fire SHALL be 0 in IDLE.
REQ-017 In LOCKED, grant_id SHALL hold for the whole packet (wormhole); requests from other ports SHALL be ignored.
REQ-018 If the granted port deasserts req while LOCKED, the block SHALL keep the lock and produce no fire (bubble); it SHALL NOT release.
REQ-019 On flit_fire with tail[grant_id]=1, the block SHALL set last=grant_id, clear grant_valid and return to IDLE on the next edge; re-arbitration then takes 1 more cycle (minimum 1 idle cycle between packets).
REQ-020 Credit update rules (each bullet one case):
- fire only: credits-1.
- credit_in only: credits+1.
- both in the same cycle: credits unchanged.
REQ-021 credits SHALL never go below 0; this is guaranteed because fire requires credits!=0.
REQ-022 On credit_in with credits==CREDIT_MAX and no fire, the block SHALL hold credits at CREDIT_MAX and set credit_err=1; credit_err stays 1 until reset.
REQ-023 When credits reach 0 mid-packet, the block SHALL hold the lock, set flit_fire=0, and resume firing the cycle after credits>0.
REQ-024 The tail input of non-granted ports SHALL be ignored; tail without fire SHALL have no effect.

Reset
REQ-025 When reset=0 at a clock edge, the block SHALL set state=IDLE, grant_valid=0, grant_id=0, last=3 (port 0 highest priority first), credits=CREDIT_MAX and credit_err=0.
REQ-026 Reset SHALL override all other inputs in that cycle, including mid-packet in LOCKED; any in-flight lock SHALL be abandoned without a release.
REQ-027 Outputs during and immediately after reset SHALL be grant_valid=0 and flit_fire=0.

Verification
REQ-028 Scenario: after reset, req=4'b1111, tail=4'b1111 held -> grants in order 0,1,2,3,0, each grant_valid for 1 cycle with 1 idle cycle between, credit_in pulsed every fire.
REQ-029 Scenario: port 2 granted, 3-flit packet (tail on 3rd fire), req=4'b0101 throughout -> grant_id stays 2 for 3 fires, port 0 is never granted mid-packet, next grant is 0.
REQ-030 Scenario: CREDIT_MAX=4, no credit_in, 6-flit packet -> 4 fires, then credits=0 and flit_fire=0 with the lock held; one credit_in pulse -> credits 1, then 1 fire, then 0.
REQ-031 Scenario: fire and credit_in in the same cycle at credits=2 -> credits remains 2; credit_in at credits=4 with no fire -> credits 4 and credit_err=1 sticky.
REQ-032 Scenario: reset=0 asserted while LOCKED with credits=1 -> next cycle grant_valid=0, grant_id=0, credits=4, credit_err=0; then req=4'b1000 -> grant_id=3.
REQ-033 Scenario: granted port drops req for 3 cycles mid-packet -> lock held, flit_fire=0 and credits unchanged for those cycles, then transfer resumes.

Source files
------------

// File: rtl/output_port_allocator.sv
// output_port_allocator: wormhole round-robin output arbiter with downstream credit tracking
module output_port_allocator #(
    parameter int CREDIT_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] tail,
    input  logic       credit_in,
    output logic       grant_valid,
    output logic [1:0] grant_id,
    output logic       flit_fire,
    output logic [2:0] credits,
    output logic       credit_err
);
    typedef enum logic {IDLE, LOCKED} state_t;
    localparam logic [2:0] CMAX = 3'(CREDIT_MAX);
    state_t     state_q, state_d;
    logic [1:0] grant_id_q, grant_id_d, last_q, last_d, winner;
    logic [2:0] credits_q, credits_d;
    logic       credit_err_q, credit_err_d;

    // descending scan so the nearest port after last wins; offset 4 wraps to last itself
    always_comb begin
        winner = last_q;
        for (int i = 4; i >= 1; i--)
            if (req[last_q + 2'(i)]) winner = last_q + 2'(i);
    end

    assign grant_valid = state_q == LOCKED;
    assign grant_id    = grant_id_q;
    assign flit_fire   = grant_valid & req[grant_id_q] & (credits_q != 3'd0);
    assign credits     = credits_q;
    assign credit_err  = credit_err_q;

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_d       = last_q;
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        if (state_q == IDLE && |req && credits_q != 3'd0) begin
            state_d    = LOCKED;
            grant_id_d = winner;
        end
        if (flit_fire && tail[grant_id_q]) begin
            state_d = IDLE;
            last_d  = grant_id_q;
        end
        if (flit_fire && !credit_in)
            credits_d = credits_q - 3'd1;
        else if (!flit_fire && credit_in) begin
            if (credits_q == CMAX) credit_err_d = 1'b1;
            else credits_d = credits_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_id_q   <= 2'd0;
            last_q       <= 2'd3;
            credits_q    <= CMAX;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_q       <= last_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
        end
    end
endmodule

// File: tb/tb_output_port_allocator.sv
// tb_output_port_allocator: scenario tasks with a fire scoreboard checking which port transfers each flit
module tb_output_port_allocator;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = 4'd0;
    logic [3:0] tail = 4'd0;
    logic       credit_in = 1'b0;
    logic       grant_valid, flit_fire, credit_err;
    logic [1:0] grant_id;
    logic [2:0] credits;
    int         vectors = 0;
    int         miscompares = 0;
    int         exp_q[$];

    output_port_allocator #(.CREDIT_MAX(4)) dut (
        .clk(clk), .reset(reset), .req(req), .tail(tail), .credit_in(credit_in),
        .grant_valid(grant_valid), .grant_id(grant_id), .flit_fire(flit_fire),
        .credits(credits), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    // every observed fire must match the next expected port in order
    always @(negedge clk) begin
        if (flit_fire) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_fire: fire from port %0d, none expected", grant_id);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (grant_id !== 2'(e)) begin
                    miscompares++;
                    $display("FAIL sb_fire: fire from port %0d, expected port %0d", grant_id, e);
                end
            end
        end
    end

    task automatic drain_check(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d expected fires never seen, want 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 4'b1111; tail = 4'b1111; credit_in = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({grant_valid, grant_id, flit_fire, credits, credit_err} !== {1'b0, 2'd0, 1'b0, 3'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got gv=%0d gid=%0d fire=%0d cr=%0d err=%0d, want 0 0 0 4 0",
                     grant_valid, grant_id, flit_fire, credits, credit_err);
        end
        @(posedge clk); #1;
        reset = 1'b1; req = 4'd0; tail = 4'd0; credit_in = 1'b0;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 5; i++) exp_q.push_back(i % 4);
        req = 4'b1111; tail = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            logic       egv;
            logic [1:0] egd;
            egv = k[0];
            egd = 2'((k / 2) % 4);
            credit_in = egv;
            @(negedge clk);
            vectors++;
            if ({grant_valid, egv ? grant_id : 2'd0, flit_fire, credits} !== {egv, egv ? egd : 2'd0, egv, 3'd4}) begin
                miscompares++;
                $display("FAIL round_robin cyc %0d: got gv=%0d gid=%0d fire=%0d cr=%0d, want gv=%0d gid=%0d fire=%0d cr=4",
                         k, grant_valid, grant_id, flit_fire, credits, egv, egd, egv);
            end
            @(posedge clk); #1;
        end
        req = 4'd0; tail = 4'd0; credit_in = 1'b0;
        drain_check("round_robin");
    endtask

    // columns: req, tail, credit_in | grant_valid, grant_id (if valid), fire, credits, credit_err
    task automatic test_wormhole();
        int t[6][8];
        t = '{'{5, 1, 0, 0, 0, 0, 4, 0}, '{5, 1, 1, 1, 2, 1, 4, 0}, '{5, 1, 1, 1, 2, 1, 4, 0},
              '{5, 4, 1, 1, 2, 1, 4, 0}, '{5, 1, 0, 0, 0, 0, 4, 0}, '{5, 1, 1, 1, 0, 1, 4, 0}};
        exp_q = '{2, 2, 2, 0};
        for (int k = 0; k < 6; k++) begin
            req = 4'(t[k][0]); tail = 4'(t[k][1]); credit_in = 1'(t[k][2]);
            @(negedge clk);
            vectors++;
            if ({grant_valid, t[k][3] != 0 ? grant_id : 2'd0, flit_fire, credits, credit_err} !==
                {1'(t[k][3]), 2'(t[k][4]), 1'(t[k][5]), 3'(t[k][6]), 1'(t[k][7])}) begin
                miscompares++;
                $display("FAIL wormhole cyc %0d: got gv=%0d gid=%0d fire=%0d cr=%0d err=%0d, want %0d %0d %0d %0d %0d",
                         k, grant_valid, grant_id, flit_fire, credits, credit_err, t[k][3], t[k][4], t[k][5], t[k][6], t[k][7]);
            end
            @(posedge clk); #1;
        end
        req = 4'd0; tail = 4'd0; credit_in = 1'b0;
        drain_check("wormhole");
    endtask

    task automatic test_credit_stall();
        int t[16][8];
        t = '{'{2, 0, 0, 0, 0, 0, 4, 0}, '{2, 0, 0, 1, 1, 1, 4, 0}, '{2, 0, 0, 1, 1, 1, 3, 0},
              '{2, 0, 0, 1, 1, 1, 2, 0}, '{2, 0, 0, 1, 1, 1, 1, 0}, '{2, 0, 0, 1, 1, 0, 0, 0},
              '{2, 0, 0, 1, 1, 0, 0, 0}, '{2, 0, 1, 1, 1, 0, 0, 0}, '{2, 0, 0, 1, 1, 1, 1, 0},
              '{2, 0, 0, 1, 1, 0, 0, 0}, '{2, 0, 1, 1, 1, 0, 0, 0}, '{2, 2, 0, 1, 1, 1, 1, 0},
              '{2, 0, 1, 0, 0, 0, 0, 0}, '{0, 0, 1, 0, 0, 0, 1, 0}, '{0, 0, 1, 0, 0, 0, 2, 0},
              '{0, 0, 1, 0, 0, 0, 3, 0}};
        exp_q = '{1, 1, 1, 1, 1, 1};
        for (int k = 0; k < 16; k++) begin
            req = 4'(t[k][0]); tail = 4'(t[k][1]); credit_in = 1'(t[k][2]);
            @(negedge clk);
            vectors++;
            if ({grant_valid, t[k][3] != 0 ? grant_id : 2'd0, flit_fire, credits, credit_err} !==
                {1'(t[k][3]), 2'(t[k][4]), 1'(t[k][5]), 3'(t[k][6]), 1'(t[k][7])}) begin
                miscompares++;
                $display("FAIL credit_stall cyc %0d: got gv=%0d gid=%0d fire=%0d cr=%0d err=%0d, want %0d %0d %0d %0d %0d",
                         k, grant_valid, grant_id, flit_fire, credits, credit_err, t[k][3], t[k][4], t[k][5], t[k][6], t[k][7]);
            end
            @(posedge clk); #1;
        end
        req = 4'd0; tail = 4'd0; credit_in = 1'b0;
        drain_check("credit_stall");
    endtask

    task automatic test_credit_same_cycle();
        int t[11][8];
        t = '{'{4, 0, 0, 0, 0, 0, 4, 0}, '{4, 0, 0, 1, 2, 1, 4, 0}, '{4, 0, 0, 1, 2, 1, 3, 0},
              '{4, 0, 1, 1, 2, 1, 2, 0}, '{4, 4, 0, 1, 2, 1, 2, 0}, '{0, 0, 1, 0, 0, 0, 1, 0},
              '{0, 0, 1, 0, 0, 0, 2, 0}, '{0, 0, 1, 0, 0, 0, 3, 0}, '{0, 0, 1, 0, 0, 0, 4, 0},
              '{0, 0, 0, 0, 0, 0, 4, 1}, '{0, 0, 0, 0, 0, 0, 4, 1}};
        exp_q = '{2, 2, 2, 2};
        for (int k = 0; k < 11; k++) begin
            req = 4'(t[k][0]); tail = 4'(t[k][1]); credit_in = 1'(t[k][2]);
            @(negedge clk);
            vectors++;
            if ({grant_valid, t[k][3] != 0 ? grant_id : 2'd0, flit_fire, credits, credit_err} !==
                {1'(t[k][3]), 2'(t[k][4]), 1'(t[k][5]), 3'(t[k][6]), 1'(t[k][7])}) begin
                miscompares++;
                $display("FAIL credit_same_cycle cyc %0d: got gv=%0d gid=%0d fire=%0d cr=%0d err=%0d, want %0d %0d %0d %0d %0d",
                         k, grant_valid, grant_id, flit_fire, credits, credit_err, t[k][3], t[k][4], t[k][5], t[k][6], t[k][7]);
            end
            @(posedge clk); #1;
        end
        req = 4'd0; tail = 4'd0; credit_in = 1'b0;
        drain_check("credit_same_cycle");
    endtask

    // reset lands while locked at one credit; grant_id is checked on every cycle here
    task automatic test_reset_mid_packet();
        int t[8][8];
        t = '{'{1, 0, 0, 0, 2, 0, 4, 1}, '{1, 0, 0, 1, 0, 1, 4, 1}, '{1, 0, 0, 1, 0, 1, 3, 1},
              '{1, 0, 0, 1, 0, 1, 2, 1}, '{0, 0, 0, 1, 0, 0, 1, 1}, '{8, 0, 0, 0, 0, 0, 4, 0},
              '{8, 8, 0, 1, 3, 1, 4, 0}, '{0, 0, 1, 0, 3, 0, 3, 0}};
        exp_q = '{0, 0, 0, 3};
        for (int k = 0; k < 8; k++) begin
            req = 4'(t[k][0]); tail = 4'(t[k][1]); credit_in = 1'(t[k][2]);
            reset = (k == 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            vectors++;
            if ({grant_valid, grant_id, flit_fire, credits, credit_err} !==
                {1'(t[k][3]), 2'(t[k][4]), 1'(t[k][5]), 3'(t[k][6]), 1'(t[k][7])}) begin
                miscompares++;
                $display("FAIL reset_mid_packet cyc %0d: got gv=%0d gid=%0d fire=%0d cr=%0d err=%0d, want %0d %0d %0d %0d %0d",
                         k, grant_valid, grant_id, flit_fire, credits, credit_err, t[k][3], t[k][4], t[k][5], t[k][6], t[k][7]);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1; req = 4'd0; tail = 4'd0; credit_in = 1'b0;
        drain_check("reset_mid_packet");
    endtask

    task automatic test_bubble();
        int t[7][8];
        t = '{'{1, 0, 0, 0, 0, 0, 4, 0}, '{1, 0, 0, 1, 0, 1, 4, 0}, '{14, 1, 0, 1, 0, 0, 3, 0},
              '{14, 1, 0, 1, 0, 0, 3, 0}, '{14, 1, 0, 1, 0, 0, 3, 0}, '{1, 1, 0, 1, 0, 1, 3, 0},
              '{0, 0, 0, 0, 0, 0, 2, 0}};
        exp_q = '{0, 0};
        for (int k = 0; k < 7; k++) begin
            req = 4'(t[k][0]); tail = 4'(t[k][1]); credit_in = 1'(t[k][2]);
            @(negedge clk);
            vectors++;
            if ({grant_valid, t[k][3] != 0 ? grant_id : 2'd0, flit_fire, credits, credit_err} !==
                {1'(t[k][3]), 2'(t[k][4]), 1'(t[k][5]), 3'(t[k][6]), 1'(t[k][7])}) begin
                miscompares++;
                $display("FAIL bubble cyc %0d: got gv=%0d gid=%0d fire=%0d cr=%0d err=%0d, want %0d %0d %0d %0d %0d",
                         k, grant_valid, grant_id, flit_fire, credits, credit_err, t[k][3], t[k][4], t[k][5], t[k][6], t[k][7]);
            end
            @(posedge clk); #1;
        end
        req = 4'd0; tail = 4'd0; credit_in = 1'b0;
        drain_check("bubble");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit_stall();
        test_credit_same_cycle();
        test_reset_mid_packet();
        test_bubble();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
